// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and sizing for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;
  localparam int REG_W     = 3;
  localparam int DRAIN_CYC = 3;
  localparam int CNT_W     = 2;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_HALTED  = 2'd3
  } haz_state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idix_en;
    logic idix_bubble;
    logic ixmem_en;
    logic memwb_en;
  } haz_ctrl_t;

  localparam haz_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam haz_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam haz_ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam haz_ctrl_t CTRL_LDUSE  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam haz_ctrl_t CTRL_HALT   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam haz_ctrl_t CTRL_DRAIN  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
endpackage

// File: rtl/pipe_hazard_ctrl_haz_detect.sv
// Load-use comparator: load in IX whose destination feeds a source read in ID.
module haz_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             ix_mem_rd,
  input  logic             ix_wr_en,
  input  logic [REG_W-1:0] ix_rd,
  output logic             load_use
);
  assign load_use = ix_mem_rd & ix_wr_en &
                    ((id_rs_used & (id_rs == ix_rd)) | (id_rt_used & (id_rt == ix_rd)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipe (load-use, memory wait, branch kill, HALT drain).
// Optional HAZ_PERF_EN adds saturating stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_halt,
  input  logic             ix_mem_rd,
  input  logic             ix_wr_en,
  input  logic [REG_W-1:0] ix_rd,
  input  logic             ix_br_taken,
  input  logic             mem_busy,
  input  logic             mem_done,
`ifdef HAZ_PERF_EN
  output logic [15:0]      perf_stall_cnt,
  output logic [15:0]      perf_flush_cnt,
`endif
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idix_stall,
  output logic             idix_bubble,
  output logic             ixmem_en,
  output logic             memwb_en,
  output logic             halted
);
  haz_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  haz_ctrl_t        ctrl;
  logic             load_use, mem_hold, br_flush, halted_c;

  haz_detect u_haz_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .ix_mem_rd  (ix_mem_rd),
    .ix_wr_en   (ix_wr_en),
    .ix_rd      (ix_rd),
    .load_use   (load_use)
  );

  assign mem_hold = mem_busy & ~mem_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ctrl      = CTRL_RUN;
    br_flush  = 1'b0;
    halted_c  = 1'b0;
    case (state)
      ST_RUN, ST_MEMWAIT: begin
        if (mem_hold || (state == ST_MEMWAIT && !mem_done)) begin
          ctrl      = CTRL_FREEZE;
          state_nxt = ST_MEMWAIT;
        end else begin
          // Completion cycle of a wait is an ordinary RUN cycle for ID/IX.
          state_nxt = ST_RUN;
          if (ix_br_taken) begin
            ctrl     = CTRL_BRANCH;
            br_flush = 1'b1;
          end else if (load_use) begin
            ctrl = CTRL_LDUSE;
          end else if (id_halt) begin
            ctrl      = CTRL_HALT;
            cnt_nxt   = CNT_W'(DRAIN_CYC - 1);
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (mem_hold) begin
          ctrl = CTRL_FREEZE;
        end else begin
          ctrl = CTRL_DRAIN;
          if (cnt <= CNT_W'(1)) begin
            cnt_nxt   = '0;
            state_nxt = ST_HALTED;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
      end
      ST_HALTED: begin
        ctrl     = CTRL_FREEZE;
        halted_c = 1'b1;
      end
      default: state_nxt = ST_RUN;
    endcase
    // Reset releases the pipe regardless of what ID/IX present.
    if (!rst) begin
      ctrl     = CTRL_RUN;
      br_flush = 1'b0;
      halted_c = 1'b0;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idix_stall  = ~ctrl.idix_en;
  assign idix_bubble = ctrl.idix_bubble;
  assign ixmem_en    = ctrl.ixmem_en;
  assign memwb_en    = ctrl.memwb_en;
  assign halted      = halted_c;

`ifdef HAZ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else if (state != ST_HALTED) begin
      if (!ctrl.pc_en && perf_stall_cnt != 16'hFFFF) perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (br_flush && perf_flush_cnt != 16'hFFFF)    perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a rule-level reference model checked every cycle.
module tb_pipe_hazard_ctrl;
  localparam int RW = 3;
  localparam int DC = 3;
  // Output vector order: pc_en ifid_en ifid_flush idix_stall idix_bubble ixmem_en memwb_en halted
  localparam logic [7:0] V_NORM   = 8'b1100_0110;
  localparam logic [7:0] V_FROZEN = 8'b0001_0000;
  localparam logic [7:0] V_BR     = 8'b1110_1110;
  localparam logic [7:0] V_LU     = 8'b0000_1110;
  localparam logic [7:0] V_HALT   = 8'b0110_0110;
  localparam logic [7:0] V_DRAIN  = 8'b0110_1110;
  localparam logic [7:0] V_HALTED = 8'b0001_0001;

  logic clk = 1'b0;
  logic rst;
  logic [RW-1:0] id_rs, id_rt, ix_rd;
  logic id_rs_used, id_rt_used, id_halt, ix_mem_rd, ix_wr_en, ix_br_taken, mem_busy, mem_done;
  logic pc_en, ifid_en, ifid_flush, idix_stall, idix_bubble, ixmem_en, memwb_en, halted;
`ifdef HAZ_PERF_EN
  logic [15:0] perf_stall_cnt, perf_flush_cnt;
`endif
  logic [7:0] outv;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_halt(id_halt), .ix_mem_rd(ix_mem_rd), .ix_wr_en(ix_wr_en), .ix_rd(ix_rd),
    .ix_br_taken(ix_br_taken), .mem_busy(mem_busy), .mem_done(mem_done),
`ifdef HAZ_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idix_stall(idix_stall),
    .idix_bubble(idix_bubble), .ixmem_en(ixmem_en), .memwb_en(memwb_en), .halted(halted)
  );

  always #5 clk = ~clk;
  assign outv = {pc_en, ifid_en, ifid_flush, idix_stall, idix_bubble, ixmem_en, memwb_en, halted};

  // Reference model: cycles elapsed since HALT left ID (-1 = none) and a pending-memory flag.
  int halt_age = -1;
  bit waiting  = 1'b0;

  function automatic bit m_lu();
    bit rs_hit = id_rs_used && (int'(id_rs) == int'(ix_rd));
    bit rt_hit = id_rt_used && (int'(id_rt) == int'(ix_rd));
    return ix_mem_rd && ix_wr_en && (rs_hit || rt_hit);
  endfunction

  function automatic logic [7:0] model_out();
    bit hold = mem_busy && !mem_done;
    if (!rst) return V_NORM;
    if (halt_age >= DC) return V_HALTED;
    if (halt_age >= 1) return hold ? V_FROZEN : V_DRAIN;
    if (hold || (waiting && !mem_done)) return V_FROZEN;
    if (ix_br_taken) return V_BR;
    if (m_lu()) return V_LU;
    if (id_halt) return V_HALT;
    return V_NORM;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      halt_age <= -1;
      waiting  <= 1'b0;
    end else if (halt_age >= DC) begin
      halt_age <= halt_age;
    end else if (halt_age >= 1) begin
      if (!(mem_busy && !mem_done)) halt_age <= halt_age + 1;
    end else if ((mem_busy && !mem_done) || (waiting && !mem_done)) begin
      waiting <= 1'b1;
    end else begin
      waiting <= 1'b0;
      if (!ix_br_taken && !m_lu() && id_halt) halt_age <= 1;
    end
  end

  always @(negedge clk) begin
    logic [7:0] e;
    e = model_out();
    cyc++;
    checks++;
    if (outv !== e) begin
      errors++;
      $display("FAIL model cyc=%0d got=%b exp=%b", cyc, outv, e);
    end
  end

  task automatic clr();
    id_rs = '0; id_rt = '0; ix_rd = '0;
    id_rs_used = 0; id_rt_used = 0; id_halt = 0; ix_mem_rd = 0; ix_wr_en = 0;
    ix_br_taken = 0; mem_busy = 0; mem_done = 0;
  endtask

  task automatic now(input string nm, input logic [7:0] exp);
    checks++;
    if (outv !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", nm, outv, exp);
    end
  endtask

  task automatic lit(input string nm, input logic [7:0] exp);
    @(negedge clk);
    now(nm, exp);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic set_lu(input logic [RW-1:0] rd);
    ix_mem_rd = 1; ix_wr_en = 1; ix_rd = rd;
  endtask

  initial begin
    clr();
    rst = 0; mem_busy = 1; id_halt = 1;
    lit("reset_vals", V_NORM);
    @(posedge clk); #1; rst = 1; clr();

    lit("idle", V_NORM); adv();
    set_lu(3); id_rs = 3; id_rs_used = 1;
    lit("lu_rs", V_LU); adv();
    id_rs = 3; id_rs_used = 1;
    lit("lu_one_bubble", V_NORM); adv();
    set_lu(3); id_rs = 3;
    lit("lu_rs_unused", V_NORM); adv();
    ix_mem_rd = 1; ix_rd = 3; id_rs = 3; id_rs_used = 1;
    lit("lu_no_wr", V_NORM); adv();
    set_lu(5); id_rt = 5; id_rt_used = 1; id_rs = 2; id_rs_used = 1;
    lit("lu_rt", V_LU); adv();
    set_lu(3); id_rs = 3; id_rs_used = 1; ix_br_taken = 1;
    lit("br_over_lu", V_BR); adv();
    ix_br_taken = 1; id_halt = 1;
    lit("br_over_halt", V_BR);
`ifdef HAZ_PERF_EN
    checks++;
    if (perf_stall_cnt !== 16'd2 || perf_flush_cnt !== 16'd1) begin
      errors++;
      $display("FAIL perf got=%0d/%0d exp=2/1", perf_stall_cnt, perf_flush_cnt);
    end
`endif
    adv();
    lit("no_drain_after_br", V_NORM); adv();
    set_lu(0); id_rs = 0; id_rs_used = 1;
    lit("lu_reg0", V_LU); adv();

    for (int i = 0; i < 3; i++) begin
      mem_busy = 1;
      lit("memwait", V_FROZEN); adv();
    end
    mem_busy = 1; mem_done = 1;
    lit("mem_done", V_NORM); adv();
    lit("mem_back_run", V_NORM); adv();

    mem_busy = 1; ix_br_taken = 1;
    lit("mem_over_br", V_FROZEN); adv();
    mem_done = 1; ix_br_taken = 1;
    lit("done_br", V_BR); adv();
    mem_busy = 1;
    lit("mem2", V_FROZEN); adv();
    lit("memwait_idle_bus", V_FROZEN); adv();
    mem_done = 1; set_lu(4); id_rt = 4; id_rt_used = 1;
    lit("done_lu", V_LU); adv();
    mem_done = 1;
    lit("stray_done", V_NORM); adv();

    mem_busy = 1;
    lit("pre_rst_mem", V_FROZEN); adv();
    mem_busy = 1;
    lit("pre_rst_wait", V_FROZEN);
    #2 rst = 0;
    #1 now("rst_in_wait", V_NORM);
    @(posedge clk); #1; rst = 1; clr();
    lit("after_rst_run", V_NORM); adv();

    id_halt = 1;
    lit("halt_cyc", V_HALT); adv();
    lit("drain1", V_DRAIN); adv();
    lit("drain2", V_DRAIN); adv();
    lit("halted", V_HALTED); adv();
    ix_br_taken = 1; set_lu(1); id_rs = 1; id_rs_used = 1;
    lit("halted_sticky", V_HALTED); adv();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
